sc_dmem_arbiter: RTL and testbench
==================================

# sc_dmem_arbiter

Two-master arbiter that shares the single-port synchronous data memory of the single-cycle computer between the CPU load/store port (master 0) and a second requester (master 1: loader/debug/DMA port). Accepts one transaction at a time, chooses the winner round-robin, drives the memory-side address/data/write-enable from registers, and returns read data to the owning master after a fixed memory latency. It sits between the requesters and `sc_datamem`, and is clocked by the memory-side clock.

## Interface
- `ADDR_W`, 32, address width (byte address, passed through unchanged)
- `DATA_W`, 32, data width
- `RD_LAT`, 1, memory read latency in cycles after the address is sampled (≥1)

Ports:
- `clock`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `m0_req`, `m1_req`  in  1  request; held with stable command until `mN_gnt`
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read
- `m0_addr`, `m1_addr`  in  ADDR_W  address
- `m0_wdata`, `m1_wdata`  in  DATA_W  write data
- `m0_gnt`, `m1_gnt`  out  1  one-cycle pulse: command taken
- `m0_rvalid`, `m1_rvalid`  out  1  one-cycle pulse: `mN_rdata` valid
- `m0_rdata`, `m1_rdata`  out  DATA_W  read data, held until next read completion for that master
- `mem_en`  out  1  memory access strobe
- `mem_we`  out  1  memory write enable, qualified by `mem_en`
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data
- `busy`  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- **IDLE:** the arbiter samples requests only in this state.
  - If no request is pending, it stays in IDLE.
  - Otherwise it picks the winner, registers the winner's `we/addr/wdata` into `mem_*`, sets `mem_en`, sets the winner's `gnt`, records `owner`, and moves to ISSUE.
- **Arbitration:**
  - Single requester: that master wins.
  - Both requesting: the master that was not granted last wins.
  - The `last` pointer resets to 1, so master 0 wins the first tie.
  - `last` updates on every grant.
- **ISSUE (1 cycle):** `mem_en`=1 and `gnt[owner]`=1.
  - Write: the memory commits at the end edge; next state is IDLE.
  - Read: next state is WAIT with the latency counter loaded to RD_LAT−1.
- **WAIT (RD_LAT cycles):** the counter decrements each cycle.
  - When the count reaches 0, `mem_rdata` is captured into `rdata[owner]` at the end edge.
  - `rvalid[owner]`=1 for the following cycle, and the state returns to IDLE.
- `mem_en`, `gnt` and `rvalid` are cleared in every cycle in which they are not explicitly set.
- `mem_addr`, `mem_wdata` and `mem_we` hold their last value when `mem_en`=0.
- **Withdrawal:** a master may drop `req` before it is granted. Nothing is issued for that request.
- A request raised while `busy`=1 waits; it is never lost.
- **Reset values:**
  - state = IDLE, `last` = 1.
  - All `gnt`, `rvalid`, `mem_en`, `mem_we` and `busy` = 0.
  - `mem_addr`, `mem_wdata` and both `rdata` = 0.
- **Reset during ISSUE/WAIT:** the transaction is aborted, no `rvalid` is produced, and the first grant after release follows the reset value of `last`.

## Timing
- Request sampled in IDLE at cycle T: ISSUE and `gnt` in T+1, `mem_en` in T+1.
- Write: back in IDLE at T+2. Minimum write-to-write spacing is 2 cycles.
- Read (RD_LAT=1): WAIT in T+2 with `mem_rdata` valid; `rvalid` and `rdata` in T+3; IDLE in T+3.
- Read (general): `rvalid` in T+2+RD_LAT.
- In the `rvalid` cycle the FSM is in IDLE and may accept a new request. Its grant appears the next cycle, overlapping nothing.
- Only one transaction is ever outstanding, so `rvalid` order always matches grant order.
- **Simultaneous events:**
  - A master whose read completes while it is requesting again: its `rvalid` and the new sampling occur in the same IDLE cycle.
  - The round-robin still applies, so the other master wins a tie.

## Test plan
- **Single write:** m0 write addr 0x10, data 0xDEADBEEF.
  - `m0_gnt` and `mem_en`=`mem_we`=1 one cycle later, with `mem_addr`=0x10 and `mem_wdata`=0xDEADBEEF.
  - `busy` falls after 2 cycles.
- **Single read:** m1 read addr 0x20 with the memory model returning 0x12345678 (RD_LAT=1).
  - `m1_gnt` in T+1, `m1_rvalid`=1 in T+3 with `m1_rdata`=0x12345678.
  - `m0_rvalid` stays 0.
- **Tie fairness:** both masters issue 4 back-to-back writes each.
  - Grants alternate m0,m1,m0,m1,… starting with m0 after reset.
  - No master is granted twice in a row while the other is requesting.
- **Latency parameter:** RD_LAT=3, m0 read.
  - `m0_rvalid` exactly 5 cycles after the request was sampled; `busy` high for 4 cycles.
- **Withdrawal and pending request:** m1 raises `req` while a m0 read is in WAIT, and m0 drops a second request before its grant.
  - m1 is granted in the cycle after m0's `rvalid` cycle.
  - The withdrawn m0 request produces no `mem_en`.
- **Reset mid-read:** assert `reset` during WAIT.
  - All outputs drop to 0 asynchronously and no `rvalid` is produced.
  - After release, a tie grants m0 first.

Source files
------------

// File: rtl/sc_dmem_arbiter.sv
// Round-robin arbiter giving two masters one-at-a-time access to the
// single-port synchronous data memory; all memory-side and master-side outputs are registered.
module sc_dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  state_e             state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic               grant_s;
  logic               winner_s;
  logic               capture_s;
  logic               last_r;
  logic               owner_r;
  logic               m0_gnt_r, m1_gnt_r;
  logic               m0_rvalid_r, m1_rvalid_r;
  logic [DATA_W-1:0]  m0_rdata_r, m1_rdata_r;
  logic               mem_en_r, mem_we_r;
  logic [ADDR_W-1:0]  mem_addr_r;
  logic [DATA_W-1:0]  mem_wdata_r;
  logic               busy_r;

  // FSM state and read-latency counter registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state, arbitration and read-capture decisions
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    grant_s   = 1'b0;
    winner_s  = 1'b0;
    capture_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (m0_req || m1_req) begin
          grant_s  = 1'b1;
          // On a tie the master not granted last time wins
          winner_s = (m0_req && m1_req) ? ~last_r : m1_req;
          state_s  = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (mem_we_r) begin
          state_s = IDLE;
        end else begin
          state_s = WAIT;
          cnt_s   = CNT_W'(RD_LAT - 1);
        end
      end
      WAIT: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          capture_s = 1'b1;
          state_s   = IDLE;
        end else begin
          cnt_s = cnt_r - CNT_W'(1);
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Registered grants, memory command, read-data return and round-robin pointer
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_r      <= 1'b1;
      owner_r     <= 1'b0;
      m0_gnt_r    <= 1'b0;
      m1_gnt_r    <= 1'b0;
      m0_rvalid_r <= 1'b0;
      m1_rvalid_r <= 1'b0;
      m0_rdata_r  <= {DATA_W{1'b0}};
      m1_rdata_r  <= {DATA_W{1'b0}};
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
      busy_r      <= 1'b0;
    end else begin
      mem_en_r    <= grant_s;
      m0_gnt_r    <= grant_s & ~winner_s;
      m1_gnt_r    <= grant_s & winner_s;
      m0_rvalid_r <= capture_s & ~owner_r;
      m1_rvalid_r <= capture_s & owner_r;
      busy_r      <= (state_s != IDLE);
      if (grant_s) begin
        owner_r     <= winner_s;
        last_r      <= winner_s;
        mem_we_r    <= winner_s ? m1_we    : m0_we;
        mem_addr_r  <= winner_s ? m1_addr  : m0_addr;
        mem_wdata_r <= winner_s ? m1_wdata : m0_wdata;
      end
      if (capture_s && !owner_r) begin
        m0_rdata_r <= mem_rdata;
      end
      if (capture_s && owner_r) begin
        m1_rdata_r <= mem_rdata;
      end
    end
  end

  assign m0_gnt    = m0_gnt_r;
  assign m1_gnt    = m1_gnt_r;
  assign m0_rvalid = m0_rvalid_r;
  assign m1_rvalid = m1_rvalid_r;
  assign m0_rdata  = m0_rdata_r;
  assign m1_rdata  = m1_rdata_r;
  assign mem_en    = mem_en_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_sc_dmem_arbiter.sv
// Directed bench for sc_dmem_arbiter: one instance with RD_LAT=1 and one with
// RD_LAT=3 share the master-side stimulus, each with its own memory model.
module tb_sc_dmem_arbiter;

  logic        clock;
  logic        reset;
  logic        m0_req, m1_req, m0_we, m1_we;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;

  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_en, mem_we, busy;
  logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata;

  logic        m0_gnt3, m1_gnt3, m0_rvalid3, m1_rvalid3, mem_en3, mem_we3, busy3;
  logic [31:0] m0_rdata3, m1_rdata3, mem_addr3, mem_wdata3, mem_rdata3;

  int vec_cnt = 0;
  int miscmp_cnt = 0;

  sc_dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1)) dut (
    .clock(clock), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  sc_dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3)) dut3 (
    .clock(clock), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt3), .m0_rvalid(m0_rvalid3), .m0_rdata(m0_rdata3),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt3), .m1_rvalid(m1_rvalid3), .m1_rdata(m1_rdata3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3), .busy(busy3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Fixed read contents; the RD_LAT=3 memory holds a different word at 0x30
  function automatic logic [31:0] rom(input logic [31:0] a, input logic slow);
    case (a)
      32'h20:  rom = 32'h1234_5678;
      32'h30:  rom = slow ? 32'hCAFE_F00D : 32'h0BAD_F00D;
      default: rom = 32'h0;
    endcase
  endfunction

  logic [31:0] rd1_q;
  logic [31:0] p3_q [0:2];
  logic [31:0] wr_addr_q, wr_data_q, wr_addr3_q, wr_data3_q;

  always @(posedge clock) begin
    if (mem_en && !mem_we) rd1_q <= rom(mem_addr, 1'b0);
    if (mem_en && mem_we) begin
      wr_addr_q <= mem_addr;
      wr_data_q <= mem_wdata;
    end
    if (mem_en3 && !mem_we3) p3_q[0] <= rom(mem_addr3, 1'b1);
    else p3_q[0] <= 32'h0;
    p3_q[1] <= p3_q[0];
    p3_q[2] <= p3_q[1];
    if (mem_en3 && mem_we3) begin
      wr_addr3_q <= mem_addr3;
      wr_data3_q <= mem_wdata3;
    end
  end
  assign mem_rdata  = rd1_q;
  assign mem_rdata3 = p3_q[2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miscmp_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int g, n0, n1;
  logic [1:0] exp_g;

  initial begin
    reset = 1'b1;
    m0_req = 1'b0; m1_req = 1'b0; m0_we = 1'b0; m1_we = 1'b0;
    m0_addr = 32'h0; m1_addr = 32'h0; m0_wdata = 32'h0; m1_wdata = 32'h0;
    tick(); tick();
    check("rst_gnt",    {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}, 4'b0000);
    check("rst_mem",    {mem_en, mem_we, busy}, 3'b000);
    check("rst_addr",   mem_addr, 32'h0);
    check("rst_wdata",  mem_wdata, 32'h0);
    check("rst_rdata",  {m0_rdata, m1_rdata}, 64'h0);
    @(negedge clock); reset = 1'b0;
    tick();

    // Single write from m0
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h10; m0_wdata = 32'hDEAD_BEEF;
    tick();
    check("wr_gnt",   {m0_gnt, m1_gnt}, 2'b10);
    check("wr_mem",   {mem_en, mem_we, busy}, 3'b111);
    check("wr_addr",  mem_addr, 32'h10);
    check("wr_wdata", mem_wdata, 32'hDEAD_BEEF);
    m0_req = 1'b0;
    tick();
    check("wr_done",   {busy, mem_en, m0_gnt}, 3'b000);
    check("wr_commit", {wr_addr_q, wr_data_q}, {32'h10, 32'hDEAD_BEEF});

    // Single read from m1
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h20;
    tick();
    check("rd_gnt", {m1_gnt, m0_gnt, mem_en, mem_we}, 4'b1010);
    m1_req = 1'b0;
    tick();
    check("rd_wait", {busy, m1_rvalid}, 2'b10);
    tick();
    check("rd_rvalid", {m1_rvalid, m0_rvalid, busy}, 3'b100);
    check("rd_data",   m1_rdata, 32'h1234_5678);
    tick();
    check("rd_hold",   {m1_rvalid, m1_rdata}, {1'b0, 32'h1234_5678});
    idle(4);

    // Tie fairness: 4 back-to-back writes per master, m0 first after reset
    reset = 1'b1; tick(); @(negedge clock); reset = 1'b0; tick();
    m0_we = 1'b1; m1_we = 1'b1; m0_addr = 32'h100; m1_addr = 32'h200;
    m0_wdata = 32'hA0; m1_wdata = 32'hB0;
    m0_req = 1'b1; m1_req = 1'b1;
    g = 0; n0 = 0; n1 = 0;
    for (int c = 0; c < 40 && g < 8; c++) begin
      tick();
      if (m0_gnt || m1_gnt) begin
        exp_g = (g % 2 == 0) ? 2'b10 : 2'b01;
        check("tie_order", {m0_gnt, m1_gnt}, exp_g);
        check("tie_dut3",  {m0_gnt3, m1_gnt3}, exp_g);
        g++;
        if (m0_gnt) begin
          n0++; m0_addr = m0_addr + 32'd4;
          if (n0 == 4) m0_req = 1'b0;
        end
        if (m1_gnt) begin
          n1++; m1_addr = m1_addr + 32'd4;
          if (n1 == 4) m1_req = 1'b0;
        end
      end
    end
    check("tie_grants", g, 8);
    m0_req = 1'b0; m1_req = 1'b0;
    idle(2);
    check("tie_last_wr3", wr_addr3_q, 32'h20C);

    // Latency: same m0 read seen by both latencies
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h30;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) m0_req = 1'b0;
      check("lat3_busy",   busy3, (k <= 4) ? 1'b1 : 1'b0);
      check("lat3_rvalid", m0_rvalid3, (k == 5) ? 1'b1 : 1'b0);
      check("lat1_rvalid", m0_rvalid, (k == 3) ? 1'b1 : 1'b0);
      if (k == 5) check("lat3_data", m0_rdata3, 32'hCAFE_F00D);
      if (k == 3) check("lat1_data", m0_rdata, 32'h0BAD_F00D);
    end

    // Pending m1 request during m0 read, withdrawn second m0 request
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h30;
    tick();
    check("wd_gnt0", m0_gnt, 1'b1);
    m0_req = 1'b0;
    tick();
    check("wd_wait", busy, 1'b1);
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h40; m1_wdata = 32'h55;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h44;
    tick();
    check("wd_rvalid", {m0_rvalid, m1_gnt, mem_en}, 3'b100);
    m0_req = 1'b0;
    tick();
    check("wd_gnt1", {m1_gnt, m0_gnt, mem_en, mem_we}, 4'b1011);
    check("wd_addr", mem_addr, 32'h40);
    m1_req = 1'b0;
    tick();
    check("wd_idle", {mem_en, busy}, 2'b00);
    tick();
    check("wd_none", {mem_en, m0_gnt}, 2'b00);
    idle(8);

    // Reset in the middle of an m0 read
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h30;
    tick();
    m0_req = 1'b0;
    tick();
    #2 reset = 1'b1;
    #1;
    check("rr_async", {busy, busy3, mem_en, mem_en3, m0_gnt}, 5'b00000);
    check("rr_rdata", {m0_rdata, m0_rdata3}, 64'h0);
    check("rr_rdata1", m1_rdata3, 32'h0);
    tick();
    @(negedge clock); reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("rr_no_rvalid", {m0_rvalid, m0_rvalid3, m1_rvalid, m1_rvalid3}, 4'b0000);
    end
    m0_req = 1'b1; m1_req = 1'b1; m0_we = 1'b1; m1_we = 1'b1;
    m0_addr = 32'h50; m1_addr = 32'h54;
    tick();
    check("rr_tie",  {m0_gnt, m1_gnt}, 2'b10);
    check("rr_tie3", {m0_gnt3, m1_gnt3}, 2'b10);
    m0_req = 1'b0; m1_req = 1'b0;
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end

endmodule
